// File: rtl/antares_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : antares_pkg
//  Description : Shared operation encodings and constants for the count
//                leading/trailing zeros/ones pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package antares_pkg;

    typedef enum logic [1:0] {
        MODE_CLZ = 2'b00,
        MODE_CLO = 2'b01,
        MODE_CTZ = 2'b10,
        MODE_CTO = 2'b11
    } mode_e;

    localparam int c_byte_w = 8;

endpackage : antares_pkg
`default_nettype wire

// File: rtl/antares_cloz_byte.sv
`default_nettype none
// ============================================================================
//  Module      : antares_cloz_byte
//  Description : Counts bits equal to i_match from bit 7 downward in one byte;
//                flags a byte whose eight bits all match.
//  Revision    : 1.0 - initial release
// ============================================================================
module antares_cloz_byte (
    input  logic [7:0] i_operand,
    input  logic       i_match,
    output logic [3:0] o_count,
    output logic       o_all_match
);

    logic w_run;

    always_comb begin
        o_count = 4'd0;
        w_run   = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            w_run = w_run && (i_operand[i] == i_match);
            if (w_run) begin
                o_count = o_count + 4'd1;
            end
        end
    end

    // A count of 8 is the only value with bit 3 set.
    assign o_all_match = o_count[3];

endmodule : antares_cloz_byte
`default_nettype wire

// File: rtl/antares_cloz_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : antares_cloz_pipe
//  Description : Two-stage valid/ready pipeline counting leading or trailing
//                zeros or ones. Trailing counts need ANTARES_CLOZ_TRAILING_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module antares_cloz_pipe
    import antares_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int RW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_result,
    output logic             out_full
);

    localparam int c_nbytes = WIDTH / c_byte_w;

    logic                     r_s1_valid;
    logic [c_nbytes-1:0][3:0] r_s1_cnt;
    logic [c_nbytes-1:0]      r_s1_all;
    logic                     r_s2_valid;
    logic [RW-1:0]            r_result;
    logic                     r_full;

    logic [WIDTH-1:0]         w_operand;
    logic                     w_match;
    logic [c_nbytes-1:0][3:0] w_byte_cnt;
    logic [c_nbytes-1:0]      w_byte_all;
    logic                     w_advance;
    logic                     w_s1_load;
    logic                     w_accept;
    logic [RW-1:0]            w_sum;
    logic                     w_run;

    // Without trailing support, mode 11 still counts ones (acts as CLO).
    assign w_match = (in_mode == MODE_CLO) || (in_mode == MODE_CTO);

`ifdef ANTARES_CLOZ_TRAILING_EN
    logic [WIDTH-1:0] w_reversed;

    always_comb begin
        w_reversed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_reversed[i] = in_data[WIDTH-1-i];
        end
    end

    // A trailing count is a leading count of the bit-reversed operand.
    assign w_operand = ((in_mode == MODE_CTZ) || (in_mode == MODE_CTO)) ? w_reversed : in_data;
`else
    assign w_operand = in_data;
`endif

    assign w_advance = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_advance;
    assign in_ready  = (!r_s1_valid || !r_s2_valid || out_ready) && !flush;
    assign w_accept  = in_valid && in_ready;

    for (genvar g = 0; g < c_nbytes; g++) begin : g_byte
        antares_cloz_byte u_byte (
            .i_operand   (w_operand[c_byte_w*g +: c_byte_w]),
            .i_match     (w_match),
            .o_count     (w_byte_cnt[g]),
            .o_all_match (w_byte_all[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cnt   <= '0;
            r_s1_all   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_cnt <= w_byte_cnt;
                r_s1_all <= w_byte_all;
            end
        end
    end

    // Sum byte counts from the top byte down until the first non-uniform byte.
    always_comb begin
        w_sum = '0;
        w_run = 1'b1;
        for (int b = c_nbytes - 1; b >= 0; b--) begin
            if (w_run) begin
                w_sum = w_sum + RW'(r_s1_cnt[b]);
            end
            w_run = w_run && r_s1_all[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_full     <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_sum;
                r_full   <= (w_sum == RW'(WIDTH));
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_result;
    assign out_full   = r_full;

endmodule : antares_cloz_pipe
`default_nettype wire

// File: tb/tb_antares_cloz_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_antares_cloz_pipe
//  Description : Directed self-checking bench for antares_cloz_pipe (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_antares_cloz_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_result;
    logic        out_full;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [5:0]  exp_q[$];
    string       cur_tag = "init";

    logic [1:0]  b2b_m [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] b2b_d [8] = '{32'h0000_0001, 32'hF000_0000, 32'h00F0_0000, 32'hFFFF_FFFE,
                               32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 32'hFFFF_0000};
    logic [5:0]  b2b_e [8] = '{6'd31, 6'd4, 6'd8, 6'd31, 6'd32, 6'd0, 6'd16, 6'd16};

    logic [1:0]  stl_m [3] = '{2'b00, 2'b01, 2'b00};
    logic [31:0] stl_d [3] = '{32'h0000_0F00, 32'hFFC0_0000, 32'h0000_0001};
    logic [5:0]  stl_e [3] = '{6'd20, 6'd10, 6'd31};

    always #5 clk = ~clk;

    antares_cloz_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_full   (out_full)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, then sample what the next rising edge sees.
    task automatic step(input logic iv, input logic [1:0] m, input logic [31:0] d,
                        input logic [5:0] e, input logic ordy, input logic fl,
                        output logic acc, output logic got);
        logic [5:0] e0;
        @(negedge clk);
        in_valid  = iv;
        in_mode   = m;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = iv && in_ready;
        got = out_valid && ordy;
        if (got) begin
            if (exp_q.size() == 0) begin
                check_eq({cur_tag, "_unexpected_out"}, 32'(out_valid), 32'd0);
            end else begin
                e0 = exp_q.pop_front();
                check_eq({cur_tag, "_result"}, 32'(out_result), 32'(e0));
                check_eq({cur_tag, "_full"}, 32'(out_full), 32'(e0 == 6'd32));
            end
        end
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(e);
    endtask

    task automatic single(input logic [1:0] m, input logic [31:0] d, input logic [5:0] e,
                          input string tag);
        logic       a;
        logic       g;
        logic [2:0] mask;
        cur_tag = tag;
        step(1'b1, m, d, e, 1'b1, 1'b0, a, g);
        mask[0] = g;
        check_eq({tag, "_accept"}, 32'(a), 32'd1);
        step(1'b0, 2'b00, 32'd0, 6'd0, 1'b1, 1'b0, a, g);
        mask[1] = g;
        step(1'b0, 2'b00, 32'd0, 6'd0, 1'b1, 1'b0, a, g);
        mask[2] = g;
        check_eq({tag, "_latency"}, 32'(mask), 32'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       a;
        logic       g;
        logic [9:0] mask10;
        int         nacc;
        int         idx;
        int         ndel;
        int         guard;
        int         j;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 2'b00;
        in_data = 32'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_out_result", 32'(out_result), 32'd0);
        check_eq("reset_out_full", 32'(out_full), 32'd0);
        rst = 1'b0;

        single(2'b00, 32'h0000_0000, 6'd32, "clz_zero");
        single(2'b00, 32'h0001_0000, 6'd15, "clz_mid");
        single(2'b01, 32'hFFFF_FFF0, 6'd28, "clo_28");
        single(2'b01, 32'h7FFF_FFFF, 6'd0,  "clo_first_miss");
        single(2'b00, 32'h8000_0000, 6'd0,  "clz_msb_set");
        single(2'b01, 32'hFFFF_FFFF, 6'd32, "clo_all");
`ifdef ANTARES_CLOZ_TRAILING_EN
        single(2'b10, 32'h0000_0100, 6'd8,  "ctz_8");
        single(2'b11, 32'h0000_00FF, 6'd8,  "cto_8");
        single(2'b10, 32'h0000_0000, 6'd32, "ctz_zero");
        single(2'b11, 32'hFFFF_FFFE, 6'd0,  "cto_first_miss");
`else
        single(2'b10, 32'h0000_0100, 6'd23, "mode10_as_clz");
        single(2'b11, 32'h0000_00FF, 6'd0,  "mode11_as_clo");
        single(2'b10, 32'h0000_0000, 6'd32, "mode10_zero");
        single(2'b11, 32'hFFFF_FFFE, 6'd31, "mode11_ones");
`endif

        // Eight back-to-back operations with the sink always ready.
        cur_tag = "b2b";
        mask10  = '0;
        nacc    = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) step(1'b1, b2b_m[k], b2b_d[k], b2b_e[k], 1'b1, 1'b0, a, g);
            else       step(1'b0, 2'b00, 32'd0, 6'd0, 1'b1, 1'b0, a, g);
            mask10[k] = g;
            if (a) nacc++;
        end
        check_eq("b2b_accepts", 32'(nacc), 32'd8);
        check_eq("b2b_timing", 32'(mask10), 32'b11_1111_1100);

        // Sink stalled for five cycles while three operations are offered.
        cur_tag = "stall";
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, stl_m[idx], stl_d[idx], stl_e[idx], 1'b0, 1'b0, a, g);
            if (a) idx++;
            if (k >= 2) begin
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_out_valid", 32'(out_valid), 32'd1);
                check_eq("stall_out_result", 32'(out_result), 32'd20);
                check_eq("stall_out_full", 32'(out_full), 32'd0);
            end
        end
        check_eq("stall_accepted", 32'(idx), 32'd2);
        ndel  = 0;
        guard = 0;
        while ((idx < 3 || exp_q.size() != 0) && guard < 20) begin
            j = (idx < 3) ? idx : 2;
            step(idx < 3, stl_m[j], stl_d[j], stl_e[j], 1'b1, 1'b0, a, g);
            if (a) idx++;
            if (g) ndel++;
            guard++;
        end
        check_eq("stall_delivered", 32'(ndel), 32'd3);
        check_eq("stall_drained", 32'(exp_q.size()), 32'd0);

        // Flush with two operations in flight and a new operand offered.
        cur_tag = "flush";
        step(1'b1, 2'b00, 32'h0001_0000, 6'd15, 1'b1, 1'b0, a, g);
        step(1'b1, 2'b01, 32'hF000_0000, 6'd4,  1'b1, 1'b0, a, g);
        step(1'b1, 2'b00, 32'h0000_0000, 6'd32, 1'b0, 1'b1, a, g);
        check_eq("flush_in_ready", 32'(in_ready), 32'd0);
        check_eq("flush_pre_out_valid", 32'(out_valid), 32'd1);
        ndel = 0;
        step(1'b0, 2'b00, 32'd0, 6'd0, 1'b1, 1'b0, a, g);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b00, 32'd0, 6'd0, 1'b1, 1'b0, a, g);
            if (g) ndel++;
        end
        check_eq("flush_no_output", 32'(ndel), 32'd0);

        // Reset in the middle of a stream.
        cur_tag = "rst";
        step(1'b1, 2'b01, 32'hFF00_0000, 6'd8,  1'b1, 1'b0, a, g);
        step(1'b1, 2'b00, 32'h0000_0010, 6'd27, 1'b1, 1'b0, a, g);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0001; in_mode = 2'b00; out_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", 32'(out_result), 32'd0);
        check_eq("rst_out_full", 32'(out_full), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        single(2'b00, 32'h0000_0400, 6'd21, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_antares_cloz_pipe
`default_nettype wire

// File: doc/antares_cloz_pipe.md
ANTARES_CLOZ_PIPE -- requirements
Module: antares_cloz_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have localparam RW = $clog2(WIDTH)+1, the result width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  discards all in-flight operations.
REQ-006 SHALL have port in_valid  input  1  operand offered.
REQ-007 SHALL have port in_ready  output  1  operand accepted when in_valid&in_ready.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port in_mode  input  2  operation: 00 CLZ, 01 CLO, 10 CTZ, 11 CTO.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready.
REQ-012 SHALL have port out_result  output  RW  count, 0..WIDTH.
REQ-013 SHALL have port out_full  output  1  high when out_result==WIDTH.

Function
REQ-014 SHALL count leading (bit WIDTH-1 downward) or trailing (bit 0 upward) zeros or ones per in_mode.
REQ-015 SHALL be a 2-stage pipeline: S1 registers per-byte counts and per-byte all-match flags; S2 combines them into out_result.
REQ-016 SHALL deliver the result 2 cycles after acceptance when out_ready is held high.
REQ-017 SHALL sustain one operation per cycle with no bubbles while out_ready is high.
REQ-018 SHALL drive in_ready = !s1_valid | !s2_valid | out_ready (combinational from out_ready, no dependence on in_valid).
REQ-019 SHALL advance S2 when !s2_valid | out_ready; SHALL advance S1 into S2 under the same condition.
REQ-020 SHALL hold out_valid, out_result and out_full stable while out_valid & !out_ready.
REQ-021 SHALL never drop or duplicate an accepted operation; results leave in acceptance order.
REQ-022 SHALL, on flush, clear s1_valid and s2_valid on the next edge, ignoring any simultaneous in_valid; in_ready SHALL be low during a flush cycle.
REQ-023 SHALL return WIDTH for all-zero operand under CLZ/CTZ and all-one operand under CLO/CTO, with out_full high.
REQ-024 SHALL return 0 when the first examined bit does not match the counted value.

Reset
REQ-025 SHALL, while rst is high, clear s1_valid, s2_valid; out_valid=0, out_result=0, out_full=0.
REQ-026 SHALL treat rst mid-operation as an abort: in-flight operations are lost, no partial result emitted.
REQ-027 SHALL give rst priority over flush and over any handshake.

Configuration
REQ-028 SHALL use macro ANTARES_CLOZ_TRAILING_EN to compile trailing-count support.
REQ-029 SHALL, with the macro defined, implement CTZ/CTO by bit-reversing in_data before S1.
REQ-030 SHALL, without the macro, ignore in_mode[1] (10 behaves as CLZ, 11 as CLO) and omit the reversal logic; port list unchanged.

Structure
REQ-031 SHALL place mode encodings (CLZ, CLO, CTZ, CTO) in shared package antares_pkg.
REQ-032 SHALL instantiate WIDTH/8 copies of sub-module antares_cloz_byte (8-bit operand, match value in; 4-bit count and all-match flag out).

Verification (WIDTH=32, macro defined unless noted)
REQ-033 SHALL cover: CLZ 0x0000_0000 -> 32, out_full=1; CLZ 0x0001_0000 -> 15; CLO 0xFFFF_FFF0 -> 28; CLO 0x7FFF_FFFF -> 0.
REQ-034 SHALL cover: CTZ 0x0000_0100 -> 8; CTO 0x0000_00FF -> 8; without macro, mode 10 on 0x0000_0100 -> 23.
REQ-035 SHALL cover: back-to-back 8 ops with out_ready=1 -> 8 results on consecutive cycles starting 2 cycles after first accept.
REQ-036 SHALL cover: out_ready low 5 cycles with 3 ops offered -> in_ready drops after 2 accepted, outputs stable, all 3 delivered in order on release.
REQ-037 SHALL cover: flush with 2 ops in flight and in_valid high -> no out_valid next cycle, flush-cycle operand not accepted.
REQ-038 SHALL cover: rst asserted mid-stream -> out_valid=0, out_result=0 next cycle; first post-reset op returns correct count with 2-cycle latency.
